// File: rtl/alu_ops_pkg.sv
// ALU op codes shared by decode, issue control and the ALU, plus the
// classification of codes into issue classes.
package alu_ops_pkg;

  localparam logic [5:0] ALU_NOP          = 6'h00;
  localparam logic [5:0] ALU_SINGLE_FIRST = 6'h01;
  localparam logic [5:0] ALU_ADD          = 6'h0C;
  localparam logic [5:0] ALU_SUB          = 6'h0D;
  localparam logic [5:0] ALU_XOR          = 6'h11;
  localparam logic [5:0] ALU_SINGLE_LAST  = 6'h1E;
  localparam logic [5:0] ALU_MUL          = 6'h1F;
  localparam logic [5:0] ALU_MULH         = 6'h20;
  localparam logic [5:0] ALU_MULHSU       = 6'h21;
  localparam logic [5:0] ALU_MULHU        = 6'h22;
  localparam logic [5:0] ALU_DIV          = 6'h23;
  localparam logic [5:0] ALU_DIVU         = 6'h24;
  localparam logic [5:0] ALU_REM          = 6'h25;
  localparam logic [5:0] ALU_REMU         = 6'h26;
  localparam logic [5:0] ALU_MULW         = 6'h27;
  localparam logic [5:0] ALU_DIVW         = 6'h28;
  localparam logic [5:0] ALU_DIVUW        = 6'h29;
  localparam logic [5:0] ALU_REMW         = 6'h2A;
  localparam logic [5:0] ALU_REMUW        = 6'h2B;

  typedef enum logic [1:0] {OP_NONE, OP_SINGLE, OP_MUL, OP_DIV} op_class_t;

  typedef enum logic {ST_IDLE, ST_BUSY} issue_state_t;

  function automatic op_class_t op_class(input logic [5:0] code);
    op_class_t c;
    c = OP_DIV;
    if (code == ALU_NOP || code > ALU_REMUW)
      c = OP_NONE;
    else if (code <= ALU_SINGLE_LAST)
      c = OP_SINGLE;
    else if (code <= ALU_MULHU || code == ALU_MULW)
      c = OP_MUL;
    return c;
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decode-side handshake, issued-op bus, writeback port and scoreboard view
// of the issue controller.
interface issue_ctrl_if;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  dec_alu_control;
  logic [4:0]  dec_addressA;
  logic [4:0]  dec_addressB;
  logic [4:0]  dec_addressC;
  logic        dec_muxB_control;
  logic        ex_valid;
  logic [5:0]  ex_alu_control;
  logic [4:0]  ex_addressA;
  logic [4:0]  ex_addressB;
  logic [4:0]  ex_addressC;
  logic        ex_muxB_control;
  logic        ex_multi;
  logic        wb_valid;
  logic [4:0]  wb_addressC;
  logic [31:0] busy_regs;

  modport master (
    output dec_valid, dec_alu_control, dec_addressA, dec_addressB,
           dec_addressC, dec_muxB_control,
    input  dec_ready, ex_valid, ex_alu_control, ex_addressA, ex_addressB,
           ex_addressC, ex_muxB_control, ex_multi, wb_valid, wb_addressC,
           busy_regs
  );

  modport slave (
    input  dec_valid, dec_alu_control, dec_addressA, dec_addressB,
           dec_addressC, dec_muxB_control,
    output dec_ready, ex_valid, ex_alu_control, ex_addressA, ex_addressB,
           ex_addressC, ex_muxB_control, ex_multi, wb_valid, wb_addressC,
           busy_regs
  );
endinterface

// File: rtl/issue_ctrl_reg_scoreboard.sv
// 32-entry pending-destination scoreboard; hazard outputs see the register
// being written back this cycle as already free.
module reg_scoreboard (
  input  logic        clk,
  input  logic        reset,
  input  logic        set_en,
  input  logic [4:0]  set_addr,
  input  logic        clr_en,
  input  logic [4:0]  clr_addr,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [4:0]  rd,
  input  logic        rs2_used,
  output logic [31:0] busy,
  output logic        raw,
  output logic        waw
);

  logic [31:0] busy_q;
  logic [31:0] clr_mask;
  logic [31:0] set_mask;
  logic [31:0] busy_eff;

  always_comb begin
    clr_mask = '0;
    set_mask = '0;
    if (clr_en)
      clr_mask[clr_addr] = 1'b1;
    if (set_en && set_addr != 5'd0)
      set_mask[set_addr] = 1'b1;
  end

  assign busy_eff = busy_q & ~clr_mask;
  assign raw      = busy_eff[rs1] | (rs2_used & busy_eff[rs2]);
  assign waw      = busy_eff[rd];
  assign busy     = busy_q;

  // Set is OR-ed after the clear so a same-cycle set of a retiring register wins.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      busy_q <= '0;
    else
      busy_q <= busy_eff | set_mask;
  end

endmodule

// File: rtl/issue_ctrl.sv
// In-order issue controller: hazard-checked handshake from decode, issued-op
// register, multi-cycle MUL/DIV sequencing and writeback port arbitration.
module issue_ctrl
  import alu_ops_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 34
) (
  input  logic         clk,
  input  logic         reset,
  issue_ctrl_if.slave  bus
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int REM_W   = (MAX_LAT > 2) ? $clog2(MAX_LAT) : 1;
  localparam logic [REM_W-1:0] MUL_REM = REM_W'(MUL_LAT - 1);
  localparam logic [REM_W-1:0] DIV_REM = REM_W'(DIV_LAT - 1);

  op_class_t        cls;
  logic             is_multi;
  logic             is_single;
  logic             raw;
  logic             waw;
  logic             ready;
  logic             issue;
  logic             multi_wb;
  logic             wb_valid;
  logic [4:0]       wb_addr;
  logic [31:0]      busy;

  issue_state_t     state;
  issue_state_t     state_n;
  logic [REM_W-1:0] rem;
  logic [REM_W-1:0] rem_n;
  logic [4:0]       mrd;
  logic [4:0]       mrd_n;

  logic             vld_p1;
  logic             multi_p1;
  logic             muxb_p1;
  logic [5:0]       alu_p1;
  logic [4:0]       ra_p1;
  logic [4:0]       rb_p1;
  logic [4:0]       rc_p1;

  assign cls       = op_class(bus.dec_alu_control);
  assign is_multi  = (cls == OP_MUL) || (cls == OP_DIV);
  assign is_single = (cls == OP_SINGLE);

  // A single-cycle op writes back in the cycle it is presented; the
  // multi-cycle result lands when the countdown reaches zero.
  assign multi_wb = (state == ST_BUSY) && (rem == '0);
  assign wb_valid = (vld_p1 && !multi_p1) || multi_wb;
  assign wb_addr  = multi_wb ? mrd : rc_p1;

  reg_scoreboard u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .set_en   (issue),
    .set_addr (bus.dec_addressC),
    .clr_en   (wb_valid),
    .clr_addr (wb_addr),
    .rs1      (bus.dec_addressA),
    .rs2      (bus.dec_addressB),
    .rd       (bus.dec_addressC),
    .rs2_used (~bus.dec_muxB_control),
    .busy     (busy),
    .raw      (raw),
    .waw      (waw)
  );

  // A single op issued at rem=1 would collide with the multi result on the
  // write port, so it waits one cycle.
  always_comb begin
    ready = 1'b0;
    if (!reset) begin
      if (cls == OP_NONE)
        ready = 1'b1;
      else
        ready = !(raw || waw)
             && !(is_multi  && state == ST_BUSY && rem != '0)
             && !(is_single && state == ST_BUSY && rem == REM_W'(1));
    end
  end

  assign issue = bus.dec_valid && ready && (cls != OP_NONE);

  always_comb begin
    state_n = state;
    rem_n   = rem;
    mrd_n   = mrd;
    if (state == ST_BUSY) begin
      if (rem != '0)
        rem_n = rem - REM_W'(1);
      else
        state_n = ST_IDLE;
    end
    if (issue && is_multi) begin
      state_n = ST_BUSY;
      rem_n   = (cls == OP_MUL) ? MUL_REM : DIV_REM;
      mrd_n   = bus.dec_addressC;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      rem   <= '0;
      mrd   <= '0;
    end else begin
      state <= state_n;
      rem   <= rem_n;
      mrd   <= mrd_n;
    end
  end

  // Stage p1: issued op presented to the datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      multi_p1 <= 1'b0;
      muxb_p1  <= 1'b0;
      alu_p1   <= '0;
      ra_p1    <= '0;
      rb_p1    <= '0;
      rc_p1    <= '0;
    end else begin
      vld_p1   <= issue;
      multi_p1 <= issue && is_multi;
      if (issue) begin
        muxb_p1 <= bus.dec_muxB_control;
        alu_p1  <= bus.dec_alu_control;
        ra_p1   <= bus.dec_addressA;
        rb_p1   <= bus.dec_addressB;
        rc_p1   <= bus.dec_addressC;
      end
    end
  end

  assign bus.dec_ready       = ready;
  assign bus.ex_valid        = vld_p1;
  assign bus.ex_multi        = multi_p1;
  assign bus.ex_alu_control  = alu_p1;
  assign bus.ex_addressA     = ra_p1;
  assign bus.ex_addressB     = rb_p1;
  assign bus.ex_addressC     = rc_p1;
  assign bus.ex_muxB_control = muxb_p1;
  assign bus.wb_valid        = wb_valid;
  assign bus.wb_addressC     = wb_addr;
  assign bus.busy_regs       = busy;

endmodule

// File: tb/tb_issue_ctrl.sv
// Bench for issue_ctrl: class-boundary vector table, directed hazard and
// reset sequences, and random traffic against a writeback-schedule model.
module tb_issue_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 34;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  issue_ctrl_if bus();

  issue_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;
  int unsigned now = 0;

  // Model: every accepted op schedules one register write at accept+latency.
  typedef struct {
    int unsigned cyc;
    logic [4:0]  rd;
    bit          multi;
  } wb_ev_t;
  wb_ev_t sched[$];

  logic       exp_ready;
  logic       e_ex_v, e_ex_m, e_muxb;
  logic [5:0] e_alu;
  logic [4:0] e_a, e_b, e_c;
  logic       dut_acc;

  typedef struct {
    logic [5:0]  alu;
    logic [4:0]  rd;
    logic        ex_v;
    logic        ex_m;
    logic        wb;
    logic [31:0] busy;
  } vec_t;
  vec_t tbl[14];

  function automatic int cls_of(input logic [5:0] c);
    if (c == 6'h00 || c > 6'h2B) return 0;
    if (c <= 6'h1E) return 1;
    if (c <= 6'h22 || c == 6'h27) return 2;
    return 3;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, now);
    end
  endtask

  task automatic cycle();
    logic [31:0] busy_obs, busy_eff;
    logic        wb_e, raw, waw;
    logic [4:0]  wb_a;
    bit          mpend, mnext;
    int          k, lat;
    @(negedge clk);
    busy_obs = '0; busy_eff = '0; wb_e = 1'b0; wb_a = '0; mpend = 0; mnext = 0;
    foreach (sched[i]) begin
      if (sched[i].cyc == now) begin
        wb_e = 1'b1;
        wb_a = sched[i].rd;
      end
      if (sched[i].rd != 5'd0) begin
        if (sched[i].cyc >= now) busy_obs[sched[i].rd] = 1'b1;
        if (sched[i].cyc > now)  busy_eff[sched[i].rd] = 1'b1;
      end
      if (sched[i].multi && sched[i].cyc > now)     mpend = 1;
      if (sched[i].multi && sched[i].cyc == now + 1) mnext = 1;
    end
    k   = cls_of(bus.dec_alu_control);
    raw = busy_eff[bus.dec_addressA] || (!bus.dec_muxB_control && busy_eff[bus.dec_addressB]);
    waw = busy_eff[bus.dec_addressC];
    if (reset)        exp_ready = 1'b0;
    else if (k == 0)  exp_ready = 1'b1;
    else              exp_ready = !raw && !waw && !(k >= 2 && mpend) && !(k == 1 && mnext);

    check("dec_ready", 32'(bus.dec_ready), 32'(exp_ready));
    check("ex_valid",  32'(bus.ex_valid),  32'(e_ex_v));
    check("ex_multi",  32'(bus.ex_multi),  32'(e_ex_m));
    if (e_ex_v)
      check("ex_fields",
            32'({bus.ex_alu_control, bus.ex_addressA, bus.ex_addressB, bus.ex_addressC, bus.ex_muxB_control}),
            32'({e_alu, e_a, e_b, e_c, e_muxb}));
    check("wb_valid", 32'(bus.wb_valid), 32'(wb_e));
    if (wb_e)
      check("wb_addressC", 32'(bus.wb_addressC), 32'(wb_a));
    check("busy_regs", bus.busy_regs, busy_obs);

    dut_acc = bus.dec_valid && bus.dec_ready;
    e_ex_v = 1'b0;
    e_ex_m = 1'b0;
    if (reset) begin
      sched.delete();
    end else if (bus.dec_valid && exp_ready && k != 0) begin
      lat = (k == 1) ? 1 : (k == 2) ? MUL_LAT : DIV_LAT;
      sched.push_back('{cyc: now + lat, rd: bus.dec_addressC, multi: (k >= 2)});
      e_ex_v = 1'b1;
      e_ex_m = (k >= 2);
      e_alu  = bus.dec_alu_control;
      e_a    = bus.dec_addressA;
      e_b    = bus.dec_addressB;
      e_c    = bus.dec_addressC;
      e_muxb = bus.dec_muxB_control;
    end
    for (int i = sched.size() - 1; i >= 0; i--)
      if (sched[i].cyc <= now) sched.delete(i);
    @(posedge clk);
    #1;
    now++;
  endtask

  task automatic idle(input int n);
    bus.dec_valid = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic pulse_reset(input int ncyc);
    bus.dec_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("rst_dec_ready", 32'(bus.dec_ready), 32'd0);
    check("rst_ex_valid",  32'(bus.ex_valid),  32'd0);
    check("rst_ex_multi",  32'(bus.ex_multi),  32'd0);
    check("rst_ex_fields",
          32'({bus.ex_alu_control, bus.ex_addressA, bus.ex_addressB, bus.ex_addressC, bus.ex_muxB_control}),
          32'd0);
    check("rst_wb_valid",  32'(bus.wb_valid),    32'd0);
    check("rst_wb_addr",   32'(bus.wb_addressC), 32'd0);
    check("rst_busy_regs", bus.busy_regs,        32'd0);
    sched.delete();
    e_ex_v = 1'b0;
    e_ex_m = 1'b0;
    repeat (ncyc) cycle();
    reset = 1'b0;
  endtask

  task automatic issue_op(input logic [5:0] alu, input logic [4:0] a, input logic [4:0] b,
                          input logic [4:0] c, input logic mb, output int stalls);
    bus.dec_valid        = 1'b1;
    bus.dec_alu_control  = alu;
    bus.dec_addressA     = a;
    bus.dec_addressB     = b;
    bus.dec_addressC     = c;
    bus.dec_muxB_control = mb;
    stalls  = 0;
    dut_acc = 1'b0;
    for (int i = 0; i < 200 && !dut_acc; i++) begin
      cycle();
      if (!dut_acc) stalls++;
    end
    check("issue_accept", 32'(dut_acc), 32'd1);
    bus.dec_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", now);
    $fatal(1, "watchdog");
  end

  initial begin
    int st, cnt, r, v;
    bus.dec_valid = 1'b0;
    bus.dec_alu_control = '0;
    bus.dec_addressA = '0;
    bus.dec_addressB = '0;
    bus.dec_addressC = '0;
    bus.dec_muxB_control = 1'b0;
    e_ex_v = 1'b0; e_ex_m = 1'b0; e_muxb = 1'b0;
    e_alu = '0; e_a = '0; e_b = '0; e_c = '0;

    tbl[0]  = '{6'h00, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1]  = '{6'h01, 5'd3, 1'b1, 1'b0, 1'b1, 32'h8};
    tbl[2]  = '{6'h1E, 5'd3, 1'b1, 1'b0, 1'b1, 32'h8};
    tbl[3]  = '{6'h1F, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[4]  = '{6'h22, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[5]  = '{6'h23, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[6]  = '{6'h26, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[7]  = '{6'h27, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[8]  = '{6'h28, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[9]  = '{6'h2B, 5'd3, 1'b1, 1'b1, 1'b0, 32'h8};
    tbl[10] = '{6'h2C, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[11] = '{6'h3F, 5'd3, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[12] = '{6'h0C, 5'd0, 1'b1, 1'b0, 1'b1, 32'h0};
    tbl[13] = '{6'h1F, 5'd0, 1'b1, 1'b1, 1'b0, 32'h0};

    #1;
    pulse_reset(2);

    foreach (tbl[i]) begin
      pulse_reset(1);
      issue_op(tbl[i].alu, 5'd0, 5'd0, tbl[i].rd, 1'b0, st);
      check($sformatf("tbl%0d_stalls", i),    32'(st),            32'd0);
      check($sformatf("tbl%0d_ex_valid", i),  32'(bus.ex_valid),  32'(tbl[i].ex_v));
      check($sformatf("tbl%0d_ex_multi", i),  32'(bus.ex_multi),  32'(tbl[i].ex_m));
      check($sformatf("tbl%0d_wb_valid", i),  32'(bus.wb_valid),  32'(tbl[i].wb));
      check($sformatf("tbl%0d_busy_regs", i), bus.busy_regs,      tbl[i].busy);
    end
    pulse_reset(1);

    // Independent ADD x1, XOR x2 back to back.
    issue_op(6'h0C, 5'd0, 5'd0, 5'd1, 1'b0, st);
    check("s1_add_stalls", 32'(st), 32'd0);
    issue_op(6'h11, 5'd0, 5'd0, 5'd2, 1'b0, st);
    check("s1_xor_stalls", 32'(st), 32'd0);
    check("s1_xor_wb", 32'({bus.wb_valid, bus.wb_addressC}), 32'({1'b1, 5'd2}));
    idle(2);

    // Dependent single ops through the writeback bypass.
    issue_op(6'h0C, 5'd1, 5'd2, 5'd3, 1'b0, st);
    issue_op(6'h0D, 5'd3, 5'd3, 5'd4, 1'b0, st);
    check("s2_sub_stalls", 32'(st), 32'd0);
    idle(2);

    // MUL x5 then dependent ADD x6.
    issue_op(6'h1F, 5'd0, 5'd0, 5'd5, 1'b0, st);
    issue_op(6'h0C, 5'd5, 5'd0, 5'd6, 1'b0, st);
    check("s3_add_stalls", 32'(st), 32'(MUL_LAT - 1));
    idle(3);

    // DIV x7, then ADDI x8 presented at rem=1 (rs2 field names x7 but is unused).
    issue_op(6'h23, 5'd0, 5'd0, 5'd7, 1'b0, st);
    idle(DIV_LAT - 2);
    issue_op(6'h0C, 5'd1, 5'd7, 5'd8, 1'b1, st);
    check("s4_addi_stalls", 32'(st), 32'd1);
    check("s4_addi_wb", 32'({bus.wb_valid, bus.wb_addressC}), 32'({1'b1, 5'd8}));
    idle(2);

    // x0 destinations and NONE ops.
    issue_op(6'h0C, 5'd0, 5'd0, 5'd0, 1'b0, st);
    check("s5_busy_add_x0", bus.busy_regs, 32'd0);
    issue_op(6'h1F, 5'd0, 5'd0, 5'd0, 1'b0, st);
    check("s5_busy_mul_x0", bus.busy_regs, 32'd0);
    idle(MUL_LAT);
    issue_op(6'h00, 5'd0, 5'd0, 5'd3, 1'b0, st);
    check("s5_none_ex_wb", 32'({bus.ex_valid, bus.wb_valid}), 32'd0);
    check("s5_none_busy", bus.busy_regs, 32'd0);
    issue_op(6'h23, 5'd0, 5'd0, 5'd9, 1'b0, st);
    issue_op(6'h30, 5'd9, 5'd9, 5'd9, 1'b0, st);
    check("s5_none_hazard_stalls", 32'(st), 32'd0);
    check("s5_none_hazard_ex", 32'(bus.ex_valid), 32'd0);
    idle(DIV_LAT);

    // Reset with a DIV in flight at rem=10.
    issue_op(6'h23, 5'd0, 5'd0, 5'd10, 1'b0, st);
    idle(DIV_LAT - 11);
    pulse_reset(1);
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      cycle();
      cnt += int'(bus.wb_valid);
    end
    check("s6_wb_after_reset", 32'(cnt), 32'd0);
    check("s6_busy_after_reset", bus.busy_regs, 32'd0);

    // Random traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      if (!bus.dec_valid && $urandom_range(0, 4) != 0) begin
        r = int'($urandom_range(0, 9));
        if (r == 0)
          bus.dec_alu_control = ($urandom_range(0, 1) == 0) ? 6'h00 : 6'($urandom_range(6'h2C, 6'h3F));
        else if (r <= 5)
          bus.dec_alu_control = 6'($urandom_range(1, 30));
        else if (r <= 7) begin
          v = int'($urandom_range(0, 4));
          bus.dec_alu_control = (v == 4) ? 6'h27 : 6'(6'h1F + v);
        end else begin
          v = int'($urandom_range(0, 7));
          bus.dec_alu_control = (v < 4) ? 6'(6'h23 + v) : 6'(6'h28 + v - 4);
        end
        bus.dec_addressA     = 5'($urandom_range(0, 7));
        bus.dec_addressB     = 5'($urandom_range(0, 7));
        bus.dec_addressC     = 5'($urandom_range(0, 7));
        bus.dec_muxB_control = 1'($urandom_range(0, 1));
        bus.dec_valid        = 1'b1;
      end
      cycle();
      if (dut_acc) bus.dec_valid = 1'b0;
      if ($urandom_range(0, 799) == 0) pulse_reset(1);
    end
    idle(DIV_LAT + 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
